// File: rtl/usb_status_pkg.sv
// Shared definitions for the USB status LED block: indication modes and
// elaboration-time parameter legality.
package usb_status_pkg;

    typedef logic [1:0] led_mode_t;

    localparam led_mode_t LED_MODE_LEGACY = 2'd0;
    localparam led_mode_t LED_MODE_BLINK  = 2'd1;
    localparam led_mode_t LED_MODE_ACT    = 2'd2;
    localparam led_mode_t LED_MODE_OFF    = 2'd3;

    function automatic bit params_ok(int unsigned cnt_w, int unsigned reload_val,
                                     int unsigned sync_stages, int unsigned blink_bit);
        // Reload must leave the MSB clear, otherwise a woken channel never leaves HELD.
        return (cnt_w >= 2) && (cnt_w <= 32) &&
               (longint'(reload_val) < (longint'(1) << (cnt_w - 1))) &&
               (sync_stages >= 2) && (blink_bit < cnt_w);
    endfunction

endpackage

// File: rtl/usb_status_led_chan.sv
// One indicator channel: sleep synchroniser, uptime counter, activity stretch
// and registered LED/awake outputs.
module usb_status_led_chan
    import usb_status_pkg::*;
#(
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned RELOAD_VAL  = 'hE0000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_W       = 16
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      pu_i,
    input  logic      sleep_i,
    input  logic      act_i,
    input  led_mode_t mode_i,
    input  logic      blink_i,
    output logic      led_o,
    output logic      awake_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACT_W-1:0]       act_q, act_d;
    logic                   led_q, led_d;
    logic                   awake_q, awake_d;
    logic                   sleep_s;
    logic                   held;

    assign sleep_s = sync_q[SYNC_STAGES-1];
    assign held    = cnt_q[CNT_W-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sleep_i};

        // MSB set freezes counting, so the counter can never wrap.
        if (!held) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!sleep_s) begin
            cnt_d = CNT_W'(RELOAD_VAL);
        end else begin
            cnt_d = cnt_q;
        end

        if (act_i && (mode_i == LED_MODE_ACT)) begin
            act_d = '1;
        end else if (act_q != '0) begin
            act_d = act_q - ACT_W'(1);
        end else begin
            act_d = act_q;
        end

        unique case (mode_i)
            LED_MODE_LEGACY: led_d = ~pu_i | ~held;
            LED_MODE_BLINK:  led_d = ~pu_i | ~held | blink_i;
            LED_MODE_ACT:    led_d = ~pu_i | (~held & (act_q == '0));
            LED_MODE_OFF:    led_d = 1'b0;
            default:         led_d = 1'b0;
        endcase

        awake_d = ~held & pu_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            led_q   <= 1'b0;
            awake_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            led_q   <= led_d;
            awake_q <= awake_d;
        end
    end

    assign led_o   = led_q;
    assign awake_o = awake_q;

endmodule

// File: rtl/usb_status_led.sv
// Multi-channel USB uptime/sleep/activity LED driver with one shared blink
// prescaler; outputs feed pad buffers directly.
module usb_status_led
    import usb_status_pkg::*;
#(
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned RELOAD_VAL  = 'hE0000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_W       = 16,
    parameter int unsigned BLINK_BIT   = 18
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [CHANNELS-1:0]   pu_i,
    input  logic [CHANNELS-1:0]   sleep_i,
    input  logic [CHANNELS-1:0]   act_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    output logic [CHANNELS-1:0]   led_o,
    output logic [CHANNELS-1:0]   awake_o
);

    if (!params_ok(CNT_W, RELOAD_VAL, SYNC_STAGES, BLINK_BIT)) begin : g_bad_params
        $error("usb_status_led: illegal parameter combination");
    end

    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic             blink;

    assign prescaler_d = prescaler_q + CNT_W'(1);
    assign blink       = prescaler_q[BLINK_BIT];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        usb_status_led_chan #(
            .CNT_W       (CNT_W),
            .RELOAD_VAL  (RELOAD_VAL),
            .SYNC_STAGES (SYNC_STAGES),
            .ACT_W       (ACT_W)
        ) u_chan (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .pu_i    (pu_i[i]),
            .sleep_i (sleep_i[i]),
            .act_i   (act_i[i]),
            .mode_i  (mode_i[2*i +: 2]),
            .blink_i (blink),
            .led_o   (led_o[i]),
            .awake_o (awake_o[i])
        );
    end

endmodule

// File: tb/tb_usb_status_led.sv
// Directed bench for usb_status_led: CNT_W=6, RELOAD_VAL=24, SYNC_STAGES=2,
// ACT_W=3, BLINK_BIT=2, two channels. Edge k after release is cyc == k.
module tb_usb_status_led;

    logic       clk;
    logic       rstn;
    logic [1:0] pu;
    logic [1:0] sleep;
    logic [1:0] act;
    logic [3:0] mode;
    logic [1:0] led;
    logic [1:0] awake;

    int tests;
    int fails;
    int cyc;

    usb_status_led #(
        .CHANNELS    (2),
        .CNT_W       (6),
        .RELOAD_VAL  (24),
        .SYNC_STAGES (2),
        .ACT_W       (3),
        .BLINK_BIT   (2)
    ) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .pu_i    (pu),
        .sleep_i (sleep),
        .act_i   (act),
        .mode_i  (mode),
        .led_o   (led),
        .awake_o (awake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Awake channel in mode 0: low exactly once every 9 cycles, first at ref_cyc.
    function automatic logic run_led(int c, int ref_cyc);
        return !(c >= ref_cyc && (c - ref_cyc) % 9 == 0);
    endfunction

    task automatic test_reset();
        rstn  = 1'b0;
        pu    = 2'b11;
        sleep = 2'b00;
        act   = 2'b00;
        mode  = 4'b0000;
        repeat (3) tick();
        tests++;
        if (led !== 2'b00) begin
            fails++;
            $display("FAIL reset_led: got %b expected %b", led, 2'b00);
        end
        tests++;
        if (awake !== 2'b00) begin
            fails++;
            $display("FAIL reset_awake: got %b expected %b", awake, 2'b00);
        end
    endtask

    task automatic test_boot_run();
        logic e;
        rstn = 1'b1;
        cyc  = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            e = run_led(cyc, 33);
            tests++;
            if ({led, awake} !== {e, e, e, e}) begin
                fails++;
                $display("FAIL boot_run cyc %0d: got led=%b awake=%b expected led=%b awake=%b",
                         cyc, led, awake, {e, e}, {e, e});
            end
        end
    endtask

    task automatic test_sleep_hold();
        logic e;
        sleep[0] = 1'b1;
        repeat (14) tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            e = run_led(cyc, 33);
            tests++;
            if ({led, awake} !== {e, 1'b0, e, 1'b0}) begin
                fails++;
                $display("FAIL sleep_hold cyc %0d: got led=%b awake=%b expected led=%b awake=%b",
                         cyc, led, awake, {e, 1'b0}, {e, 1'b0});
            end
        end
    endtask

    task automatic test_wake();
        int ref0;
        sleep[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (led[0] !== (i == 4)) begin
                fails++;
                $display("FAIL wake_latency edge %0d: got %b expected %b", i, led[0], i == 4);
            end
        end
        tests++;
        if (awake[0] !== 1'b1) begin
            fails++;
            $display("FAIL wake_awake: got %b expected 1", awake[0]);
        end
        // Reload to 24 landed one edge earlier; MSB returns 8 edges after that.
        ref0 = cyc + 8;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (led[0] !== run_led(cyc, ref0)) begin
                fails++;
                $display("FAIL wake_period cyc %0d: got %b expected %b",
                         cyc, led[0], run_led(cyc, ref0));
            end
        end
    endtask

    task automatic test_blink();
        logic e;
        sleep[0] = 1'b1;
        repeat (14) tick();
        mode[1:0] = 2'd1;
        for (int i = 0; i < 16; i++) begin
            tick();
            e = ((cyc - 1) >> 2) % 2 == 1;
            tests++;
            if (led[0] !== e) begin
                fails++;
                $display("FAIL blink cyc %0d: got %b expected %b", cyc, led[0], e);
            end
        end
        mode[1:0] = 2'd3;
        tick();
        tests++;
        if (led[0] !== 1'b0) begin
            fails++;
            $display("FAIL mode_off: got %b expected 0", led[0]);
        end
    endtask

    task automatic test_activity();
        logic e;
        int   p0;
        mode[3:2] = 2'd2;
        while (cyc % 9 != 0) tick();
        act[1] = 1'b1;
        tick();
        act[1] = 1'b0;
        p0 = cyc;
        for (int i = 1; i <= 12; i++) begin
            tick();
            e = (i <= 7) ? 1'b0 : run_led(cyc, 33);
            tests++;
            if (led[1] !== e) begin
                fails++;
                $display("FAIL act_single +%0d: got %b expected %b", cyc - p0, led[1], e);
            end
        end
        while (cyc % 9 != 0) tick();
        act[1] = 1'b1;
        tick();
        act[1] = 1'b0;
        p0 = cyc;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 3) act[1] = 1'b0;
            e = (i <= 10) ? 1'b0 : run_led(cyc, 33);
            tests++;
            if (led[1] !== e) begin
                fails++;
                $display("FAIL act_retrigger +%0d: got %b expected %b", cyc - p0, led[1], e);
            end
            if (i == 2) act[1] = 1'b1;
        end
    endtask

    task automatic test_pullup_and_reset();
        logic e0;
        logic e1;
        pu   = 2'b00;
        mode = {2'd1, 2'd0};
        tick();
        tests++;
        if ({led, awake} !== 4'b1100) begin
            fails++;
            $display("FAIL pu_off_m0m1: got led=%b awake=%b expected led=11 awake=00", led, awake);
        end
        mode = {2'd2, 2'd1};
        tick();
        tests++;
        if ({led, awake} !== 4'b1100) begin
            fails++;
            $display("FAIL pu_off_m1m2: got led=%b awake=%b expected led=11 awake=00", led, awake);
        end
        mode = {2'd0, 2'd2};
        tick();
        tests++;
        if ({led, awake} !== 4'b1100) begin
            fails++;
            $display("FAIL pu_off_m2m0: got led=%b awake=%b expected led=11 awake=00", led, awake);
        end
        mode = 4'b1111;
        tick();
        tests++;
        if (led !== 2'b00) begin
            fails++;
            $display("FAIL pu_off_m3: got %b expected 00", led);
        end
        pu   = 2'b11;
        mode = 4'b0000;
        rstn = 1'b0;
        tick();
        tests++;
        if ({led, awake} !== 4'b0000) begin
            fails++;
            $display("FAIL mid_reset: got led=%b awake=%b expected led=00 awake=00", led, awake);
        end
        rstn = 1'b1;
        cyc  = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            e0 = (cyc <= 32);
            e1 = run_led(cyc, 33);
            tests++;
            if ({led, awake} !== {e1, e0, e1, e0}) begin
                fails++;
                $display("FAIL reboot cyc %0d: got led=%b awake=%b expected led=%b awake=%b",
                         cyc, led, awake, {e1, e0}, {e1, e0});
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        test_reset();
        test_boot_run();
        test_sleep_hold();
        test_wake();
        test_blink();
        test_activity();
        test_pullup_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
